// File: rtl/lpa_run_controller_if.sv
// Handshake/control bundle between the run controller and its environment.
// Only valid/ready/last/control travel here; data, id, dest and user fields
// run directly between the sources and the array.
//
// Handshake rule for every valid/ready pair: a beat transfers on a rising
// clock edge where valid and ready are both 1; valid never depends on ready.
//
// Modports:
//   master : environment side (command source, data/weight sources, array)
//   slave  : the run controller
// Debug outputs state_dbg / beat_cnt_dbg expose the controller FSM.
interface lpa_run_controller_if #(
  parameter int NL         = 1,
  parameter int NT         = 1,
  parameter int ND         = 1,
  parameter int LEN_WIDTH  = 16,
  parameter int PASS_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [PASS_WIDTH-1:0] cmd_passes;

  logic [NL-1:0]         src_left_tvalid;
  logic [NL-1:0]         src_left_tready;
  logic [NL-1:0]         arr_left_tvalid;
  logic [NL-1:0]         arr_left_tready;
  logic [NL-1:0]         arr_left_tlast;

  logic [NT-1:0]         src_top_tvalid;
  logic [NT-1:0]         src_top_tready;
  logic [NT-1:0]         arr_top_tvalid;
  logic [NT-1:0]         arr_top_tready;
  logic [NT-1:0]         arr_top_tlast;

  logic [ND-1:0]         down_tvalid;
  logic [ND-1:0]         down_tready;
  logic [ND-1:0]         down_tlast;

  logic                  err_unalligned_data;
  logic                  err_user_flag;
  logic                  core_rst;

  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic [PASS_WIDTH-1:0] pass_idx;

  logic [2:0]            state_dbg;
  logic [LEN_WIDTH-1:0]  beat_cnt_dbg;

  modport master (
    output cmd_valid, cmd_len, cmd_passes,
    output src_left_tvalid, arr_left_tready,
    output src_top_tvalid, arr_top_tready,
    output down_tvalid, down_tready, down_tlast,
    output err_unalligned_data, err_user_flag, core_rst,
    input  cmd_ready,
    input  src_left_tready, arr_left_tvalid, arr_left_tlast,
    input  src_top_tready, arr_top_tvalid, arr_top_tlast,
    input  busy, done, aborted, pass_idx,
    input  state_dbg, beat_cnt_dbg
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_passes,
    input  src_left_tvalid, arr_left_tready,
    input  src_top_tvalid, arr_top_tready,
    input  down_tvalid, down_tready, down_tlast,
    input  err_unalligned_data, err_user_flag, core_rst,
    output cmd_ready,
    output src_left_tready, arr_left_tvalid, arr_left_tlast,
    output src_top_tready, arr_top_tvalid, arr_top_tlast,
    output busy, done, aborted, pass_idx,
    output state_dbg, beat_cnt_dbg
  );
endinterface

// File: rtl/lpa_run_controller.sv
// Run sequencer for the linear processing array.
// Accepts one command (beats per pass, number of passes), releases left/top
// beats in lock-step across all lanes, marks the last beat of each pass with
// tlast, waits for a down-side tlast on every lane, then starts the next pass.
// Array errors or core reset during a run abort it.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   ctl   : lpa_run_controller_if.slave (command, left/top/down handshakes,
//           error flags, status busy/done/aborted/pass_idx, FSM debug)
module lpa_run_controller #(
  parameter int PE_NUMBER_I = 1,
  parameter int PE_NUMBER_J = 1,
  parameter int BATCH_SIZE  = 1,
  parameter int LEN_WIDTH   = 16,
  parameter int PASS_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst_n,
  lpa_run_controller_if.slave ctl
);
  localparam int NL = PE_NUMBER_J * BATCH_SIZE;
  localparam int NT = PE_NUMBER_I * PE_NUMBER_J;
  localparam int ND = PE_NUMBER_I * BATCH_SIZE;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [PASS_WIDTH-1:0] PASS_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [PASS_WIDTH-1:0] passes_q, passes_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [PASS_WIDTH-1:0] pass_idx_q, pass_idx_d;
  logic [ND-1:0]         lane_mask_q, lane_mask_d;
  logic                  aborted_q, aborted_d;

  logic          all_v;
  logic          all_r;
  logic          fire;
  logic          beat_last;
  logic          pass_last;
  logic          abort_req;
  logic [ND-1:0] tlast_hits;
  logic [ND-1:0] mask_now;

  always_comb begin
    all_v      = (&ctl.src_left_tvalid) & (&ctl.src_top_tvalid);
    all_r      = (&ctl.arr_left_tready) & (&ctl.arr_top_tready);
    beat_last  = (beat_cnt_q == (len_q - LEN_ONE));
    pass_last  = (pass_idx_q == (passes_q - PASS_ONE));
    abort_req  = ctl.err_unalligned_data | ctl.err_user_flag | ctl.core_rst;
    tlast_hits = ctl.down_tvalid & ctl.down_tready & ctl.down_tlast;
    // Completion looks at this cycle's hits too, so the last lane's tlast
    // finishes the pass without an extra cycle.
    mask_now   = lane_mask_q | tlast_hits;
    fire       = (state_q == S_FEED) & all_v & all_r;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    passes_d    = passes_q;
    beat_cnt_d  = beat_cnt_q;
    pass_idx_d  = pass_idx_q;
    lane_mask_d = lane_mask_q;
    aborted_d   = 1'b0;

    ctl.arr_left_tvalid = '0;
    ctl.arr_top_tvalid  = '0;
    ctl.src_left_tready = '0;
    ctl.src_top_tready  = '0;
    ctl.arr_left_tlast  = '0;
    ctl.arr_top_tlast   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (ctl.cmd_valid) begin
          len_d       = ctl.cmd_len;
          passes_d    = ctl.cmd_passes;
          beat_cnt_d  = '0;
          pass_idx_d  = '0;
          lane_mask_d = '0;
          if ((ctl.cmd_len == '0) || (ctl.cmd_passes == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FEED;
          end
        end
      end

      S_FEED: begin
        ctl.arr_left_tvalid = {NL{all_v}};
        ctl.arr_top_tvalid  = {NT{all_v}};
        ctl.src_left_tready = {NL{all_v & all_r}};
        ctl.src_top_tready  = {NT{all_v & all_r}};
        ctl.arr_left_tlast  = {NL{beat_last}};
        ctl.arr_top_tlast   = {NT{beat_last}};
        if (abort_req) begin
          // Abort wins over the beat count update of this cycle.
          state_d   = S_ABORT;
          aborted_d = 1'b1;
        end else begin
          // Lanes that finish early during FEED count toward this pass.
          lane_mask_d = mask_now;
          if (fire) begin
            if (beat_last) begin
              beat_cnt_d = '0;
              state_d    = S_DRAIN;
            end else begin
              beat_cnt_d = beat_cnt_q + LEN_ONE;
            end
          end
        end
      end

      S_DRAIN: begin
        if (abort_req) begin
          state_d   = S_ABORT;
          aborted_d = 1'b1;
        end else if (&mask_now) begin
          if (pass_last) begin
            lane_mask_d = mask_now;
            state_d     = S_DONE;
          end else begin
            pass_idx_d  = pass_idx_q + PASS_ONE;
            lane_mask_d = '0;
            state_d     = S_FEED;
          end
        end else begin
          lane_mask_d = mask_now;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_ABORT: begin
        if (!abort_req) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      passes_q    <= '0;
      beat_cnt_q  <= '0;
      pass_idx_q  <= '0;
      lane_mask_q <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      passes_q    <= passes_d;
      beat_cnt_q  <= beat_cnt_d;
      pass_idx_q  <= pass_idx_d;
      lane_mask_q <= lane_mask_d;
      aborted_q   <= aborted_d;
    end
  end

  // Status outputs are pure decodes of registered state.
  always_comb begin
    ctl.cmd_ready    = (state_q == S_IDLE);
    ctl.busy         = (state_q != S_IDLE);
    ctl.done         = (state_q == S_DONE);
    ctl.aborted      = aborted_q;
    ctl.pass_idx     = pass_idx_q;
    ctl.state_dbg    = state_q;
    ctl.beat_cnt_dbg = beat_cnt_q;
  end
endmodule

// File: tb/tb_lpa_run_controller.sv
// Bench for lpa_run_controller: per-cycle vectors of inputs and expected
// outputs applied from a table, plus a hand-written async reset sequence.
module tb_lpa_run_controller;
  localparam int PE_I = 2;
  localparam int PE_J = 2;
  localparam int BS   = 1;
  localparam int NL   = PE_J * BS;
  localparam int NT   = PE_I * PE_J;
  localparam int ND   = PE_I * BS;
  localparam int LW   = 16;
  localparam int PW   = 8;

  localparam int IDL = 0;
  localparam int FED = 1;
  localparam int DRN = 2;
  localparam int DNE = 3;
  localparam int ABT = 4;

  typedef struct {
    string       name;
    logic        cv;
    logic [15:0] len;
    logic [7:0]  passes;
    logic [1:0]  slv;
    logic [3:0]  stv;
    logic [1:0]  alr;
    logic [3:0]  atr;
    logic [1:0]  dv;
    logic [1:0]  dt;
    logic        eu;
    logic        ed;
    logic        cr;
    logic        e_v;
    logic        e_r;
    logic        e_last;
    logic        e_ab;
    logic [7:0]  e_pidx;
    logic [2:0]  e_st;
    logic [15:0] e_beat;
  } vec_t;

  logic clk;
  logic rst_n;

  lpa_run_controller_if #(.NL(NL), .NT(NT), .ND(ND), .LEN_WIDTH(LW), .PASS_WIDTH(PW)) bus ();

  lpa_run_controller #(
    .PE_NUMBER_I(PE_I), .PE_NUMBER_J(PE_J), .BATCH_SIZE(BS),
    .LEN_WIDTH(LW), .PASS_WIDTH(PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus.slave)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  int n_cmp;
  int n_err;
  logic [63:0] exp_q[$];
  vec_t vecs[$];
  int split_idx;

  function automatic logic [63:0] exp_word(vec_t v);
    logic [63:0] w;
    w = {15'd0, (v.e_st == 3'(IDL)),
         {NL{v.e_v}}, {NT{v.e_v}}, {NL{v.e_r}}, {NT{v.e_r}},
         {NL{v.e_last}}, {NT{v.e_last}},
         (v.e_st != 3'(IDL)), (v.e_st == 3'(DNE)), v.e_ab,
         v.e_pidx, v.e_st, v.e_beat};
    return w;
  endfunction

  function automatic logic [63:0] act_word();
    logic [63:0] w;
    w = {15'd0, bus.cmd_ready,
         bus.arr_left_tvalid, bus.arr_top_tvalid,
         bus.src_left_tready, bus.src_top_tready,
         bus.arr_left_tlast, bus.arr_top_tlast,
         bus.busy, bus.done, bus.aborted,
         bus.pass_idx, bus.state_dbg, bus.beat_cnt_dbg};
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input int cv, input int len, input int passes,
                     input int slv, input int stv, input int alr, input int atr,
                     input int dv, input int dt, input int eu, input int ed, input int cr,
                     input int ev, input int er, input int el, input int eab,
                     input int epidx, input int est, input int ebeat);
    vec_t v;
    v.name = name;      v.cv = cv[0];           v.len = len[15:0];   v.passes = passes[7:0];
    v.slv = slv[1:0];   v.stv = stv[3:0];       v.alr = alr[1:0];    v.atr = atr[3:0];
    v.dv = dv[1:0];     v.dt = dt[1:0];         v.eu = eu[0];        v.ed = ed[0];
    v.cr = cr[0];       v.e_v = ev[0];          v.e_r = er[0];       v.e_last = el[0];
    v.e_ab = eab[0];    v.e_pidx = epidx[7:0];  v.e_st = est[2:0];   v.e_beat = ebeat[15:0];
    vecs.push_back(v);
  endtask

  // Driver: drive one cycle's inputs on the falling edge, check #1 later.
  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.cmd_valid           = v.cv;
    bus.cmd_len             = v.len;
    bus.cmd_passes          = v.passes;
    bus.src_left_tvalid     = v.slv;
    bus.src_top_tvalid      = v.stv;
    bus.arr_left_tready     = v.alr;
    bus.arr_top_tready      = v.atr;
    bus.down_tvalid         = v.dv;
    bus.down_tready         = 2'b11;
    bus.down_tlast          = v.dt;
    bus.err_user_flag       = v.eu;
    bus.err_unalligned_data = v.ed;
    bus.core_rst            = v.cr;
    exp_q.push_back(exp_word(v));
    #1;
    check(v.name, act_word(), exp_q.pop_front());
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_passes = '0;
    bus.src_left_tvalid = '0; bus.src_top_tvalid = '0;
    bus.arr_left_tready = '0; bus.arr_top_tready = '0;
    bus.down_tvalid = '0; bus.down_tready = '0; bus.down_tlast = '0;
    bus.err_user_flag = 1'b0; bus.err_unalligned_data = 1'b0; bus.core_rst = 1'b0;
  endtask

  initial begin
    vec_t rv;
    n_cmp = 0;
    n_err = 0;
    rv = '{name: "rst", default: '0};
    rv.e_st = 3'(IDL);

    //   name       cv len ps slv stv alr atr dv dt eu ed cr  v  r  l ab pidx st  beat
    // single pass, len 3
    add("sp_cmd",    1, 3, 1, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    add("sp_b0",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, FED, 0);
    add("sp_b1",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, FED, 1);
    add("sp_b2",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, FED, 2);
    add("sp_dr0",    0, 0, 0, 3, 15, 3, 15, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, DRN, 0);
    add("sp_dr1",    0, 0, 0, 3, 15, 3, 15, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, DRN, 0);
    add("sp_done",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DNE, 0);
    add("sp_idle",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    // backpressure: arr_top_tready[1] low for one cycle
    add("bp_cmd",    1, 3, 1, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    add("bp_b0",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, FED, 0);
    add("bp_stall",  0, 0, 0, 3, 15, 3, 13, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, FED, 1);
    add("bp_b1",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, FED, 1);
    add("bp_b2",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, FED, 2);
    add("bp_drn",    0, 0, 0, 3, 15, 3, 15, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, DRN, 0);
    add("bp_done",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DNE, 0);
    add("bp_idle",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    // partial valid: left lanes 2'b01 for four cycles
    add("pv_cmd",    1, 2, 1, 1, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    add("pv_w0",     0, 0, 0, 1, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FED, 0);
    add("pv_w1",     0, 0, 0, 1, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FED, 0);
    add("pv_w2",     0, 0, 0, 1, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FED, 0);
    add("pv_w3",     0, 0, 0, 1, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FED, 0);
    add("pv_b0",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, FED, 0);
    add("pv_b1",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, FED, 1);
    add("pv_nolast", 0, 0, 0, 3, 15, 3, 15, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, DRN, 0);
    add("pv_drn",    0, 0, 0, 3, 15, 3, 15, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, DRN, 0);
    add("pv_done",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DNE, 0);
    add("pv_idle",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    // multi-pass: len 2, 3 passes, staggered down tlast
    add("mp_cmd",    1, 2, 3, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    add("mp_p0b0",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, FED, 0);
    add("mp_p0b1",   0, 0, 0, 3, 15, 3, 15, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, FED, 1);
    add("mp_p0d",    0, 0, 0, 3, 15, 3, 15, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, DRN, 0);
    add("mp_p1b0",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, FED, 0);
    add("mp_p1b1",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, FED, 1);
    add("mp_p1d0",   0, 0, 0, 3, 15, 3, 15, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, DRN, 0);
    add("mp_p1d1",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DRN, 0);
    add("mp_p1d2",   0, 0, 0, 3, 15, 3, 15, 2, 2, 0, 0, 0, 0, 0, 0, 0, 1, DRN, 0);
    add("mp_p2b0",   0, 0, 0, 3, 15, 3, 15, 1, 1, 0, 0, 0, 1, 1, 0, 0, 2, FED, 0);
    add("mp_p2b1",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 1, 0, 2, FED, 1);
    add("mp_p2d",    0, 0, 0, 3, 15, 3, 15, 2, 2, 0, 0, 0, 0, 0, 0, 0, 2, DRN, 0);
    add("mp_done",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, DNE, 0);
    add("mp_idle",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, IDL, 0);
    // zero-length and zero-pass commands
    add("zc_cmd",    1, 0, 5, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, IDL, 0);
    add("zc_done",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DNE, 0);
    add("zc_idle",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    add("zp_cmd",    1, 4, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    add("zp_done",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DNE, 0);
    add("zp_idle_e", 0, 0, 0, 3, 15, 3, 15, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    // user error on the same cycle as the tlast fire
    add("ab_cmd",    1, 2, 1, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    add("ab_b0",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, FED, 0);
    add("ab_b1",     0, 0, 0, 3, 15, 3, 15, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, FED, 1);
    add("ab_wait",   0, 0, 0, 3, 15, 3, 15, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, ABT, 1);
    add("ab_clr",    0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ABT, 1);
    add("ab_idle",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 1);
    // core reset in DRAIN while the pass would complete
    add("cr_cmd",    1, 1, 1, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 1);
    add("cr_b0",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, FED, 0);
    add("cr_drn",    0, 0, 0, 3, 15, 3, 15, 3, 3, 0, 0, 1, 0, 0, 0, 0, 0, DRN, 0);
    add("cr_abt",    0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ABT, 0);
    add("cr_idle",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    // unaligned-data error held for several cycles
    add("ud_cmd",    1, 2, 1, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    add("ud_b0",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, FED, 0);
    add("ud_abt",    0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, ABT, 0);
    add("ud_hold",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ABT, 0);
    add("ud_clr",    0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ABT, 0);
    add("ud_idle",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    // len 1, 2 passes: stop in DRAIN of pass 1 for the async reset
    add("rs_cmd",    1, 1, 2, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    add("rs_b0",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, FED, 0);
    add("rs_d0",     0, 0, 0, 3, 15, 3, 15, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, DRN, 0);
    add("rs_b1",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, FED, 0);
    add("rs_d1",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DRN, 0);
    split_idx = vecs.size();
    // recovery after reset
    add("pr_cmd",    1, 1, 1, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);
    add("pr_b0",     0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, FED, 0);
    add("pr_drn",    0, 0, 0, 3, 15, 3, 15, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, DRN, 0);
    add("pr_done",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DNE, 0);
    add("pr_idle",   0, 0, 0, 3, 15, 3, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDL, 0);

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", act_word(), exp_word(rv));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < split_idx; i++) begin
      apply(vecs[i]);
    end

    // Async reset mid-cycle while in DRAIN with pass_idx 1
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", act_word(), exp_word(rv));
    @(negedge clk);
    #1;
    check("async_reset_hold", act_word(), exp_word(rv));
    rst_n = 1'b1;

    for (int i = split_idx; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lpa_run_controller.md
# lpa_run_controller

Run sequencer for the linear processing array. It accepts one run command (reduction length, number of passes), releases data (left) and weight (top) beats into the array in lock-step across all lanes, and generates `tlast` on the final beat of each pass. It tracks per-lane partial-sum `tlast` on the down outputs, advances pass by pass, and aborts cleanly on array errors or core reset. It carries handshake and control only; tdata, tid, tdest and tuser are wired directly between source and array outside this block.

## Interface
- `PE_NUMBER_I`, 1: array i dimension.
- `PE_NUMBER_J`, 1: array j dimension.
- `BATCH_SIZE`, 1: batch dimension.
- `LEN_WIDTH`, 16: width of beat-count fields.
- `PASS_WIDTH`, 8: width of pass-count fields.
- Derived widths: `NL = PE_NUMBER_J*BATCH_SIZE`, `NT = PE_NUMBER_I*PE_NUMBER_J`, `ND = PE_NUMBER_I*BATCH_SIZE`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_len` in LEN_WIDTH: beats per pass per lane.
- `cmd_passes` in PASS_WIDTH: number of passes.
- `src_left_tvalid` in NL, `src_left_tready` out NL: upstream data lanes.
- `arr_left_tvalid` out NL, `arr_left_tready` in NL, `arr_left_tlast` out NL: array left input.
- `src_top_tvalid` in NT, `src_top_tready` out NT: upstream weight lanes.
- `arr_top_tvalid` out NT, `arr_top_tready` in NT, `arr_top_tlast` out NT: array top input.
- `down_tvalid` in ND, `down_tready` in ND, `down_tlast` in ND: monitored array outputs; this block does not gate them.
- `err_unalligned_data` in 1, `err_user_flag` in 1, `core_rst` in 1: array error and reset flags.
- `busy` out 1, `done` out 1 (pulse), `aborted` out 1 (pulse), `pass_idx` out PASS_WIDTH.

## Operation
- States: IDLE, FEED, DRAIN, DONE, ABORT.
- IDLE: `cmd_ready=1`. On `cmd_valid` the block latches `len` and `passes`, clears `beat_cnt`, `pass_idx` and `lane_mask`.
  - If `len==0` or `passes==0`, go to DONE.
  - Otherwise go to FEED.
- Join rule: `all_v = &src_left_tvalid & &src_top_tvalid`; `all_r = &arr_left_tready & &arr_top_tready`.
- FEED outputs:
  - every `arr_*_tvalid = all_v`.
  - every `src_*_tready = all_v & all_r`.
  - `fire = all_v & all_r`.
  - `arr_*_tlast = (beat_cnt == len-1)`, replicated on all lanes.
- Valid never depends on ready. In all states other than FEED, all `arr_*_tvalid` and `src_*_tready` are 0.
- FEED sequencing: `beat_cnt` increments on each `fire`. A `fire` with tlast clears `beat_cnt` and moves to DRAIN.
- Lane mask: `lane_mask[k]` is set on `down_tvalid[k] & down_tready[k] & down_tlast[k]`. This is tracked in FEED and DRAIN; tlast seen in other states is ignored.
- DRAIN completes when `lane_mask | current-cycle tlast hits` is all ones.
  - If `pass_idx == passes-1`, go to DONE.
  - Otherwise `pass_idx++`, clear `lane_mask`, return to FEED.
- DONE: `done=1` for one cycle, then IDLE.
- Abort: `err_unalligned_data | err_user_flag | core_rst` in FEED or DRAIN goes to ABORT.
  - Abort has priority over completion and over `fire` bookkeeping in the same cycle.
  - ABORT asserts `aborted=1` for one cycle, then waits in ABORT until `core_rst==0` and both error flags are 0, then returns to IDLE.
- `busy = (state != IDLE)`.

## Timing
- Reset (`rst_n=0`, async): state IDLE, `cmd_ready=1`, all counters and mask 0. `busy`, `done`, `aborted`, all `arr_*_tvalid`/`tlast` and all `src_*_tready` are 0.
- Command accepted at cycle 0. FEED is active at cycle 1 and the first beat can fire at cycle 1.
- Throughput in FEED: one beat per cycle.
- DRAIN completing at cycle t gives FEED or DONE at t+1. `done` is high at t+1; `cmd_ready` is high again at t+2.
- `pass_idx` updates at the DRAIN→FEED edge and holds its final value until the next command.
- Outputs are registered-state decodes. Only `tvalid`, `tready` and `tlast` combine registered state with live inputs.

## Test plan
- **Single pass:** NL=NT=ND=2, len=3, passes=1, sources always valid, array always ready, then one tlast on each down lane → 3 fires on consecutive cycles, tlast on the 3rd, `done` pulses one cycle after the second lane's tlast.
- **Backpressure:** as above, with `arr_top_tready[1]` low on cycle 2 → no lane fires that cycle, `src_*_tready` all 0, beat count still 3, tlast only on the final beat.
- **Partial valid:** `src_left_tvalid=2'b01` for 4 cycles → all `arr_*_tvalid` stay 0, no `fire`, `beat_cnt` stays 0.
- **Multi-pass:** len=2, passes=3, down tlast arriving lane 0 then lane 1 on staggered cycles → 6 fires total, `pass_idx` steps 0→1→2, a single `done` pulse; early lane-0 tlast during FEED counts toward its pass.
- **Zero command:** `cmd_len=0`, `cmd_passes=5` → no valids asserted, `done` at cycle 1, `cmd_ready` high at cycle 2.
- **Abort and reset:** `err_user_flag` pulsed mid-FEED on the same cycle as a tlast fire → `aborted` pulse, no `done`, gating drops next cycle, IDLE after the flag clears. Separately, `rst_n` low during DRAIN → all outputs reset immediately without waiting for a clock edge.
